// File: rtl/hue_pkg.sv
// Shared types and constants for the hue_fader status-LED driver.
package hue_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_STEP = 2'd1,
      MODE_FADE = 2'd2,
      MODE_HOLD = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      SEG_RED     = 3'd0,
      SEG_YELLOW  = 3'd1,
      SEG_GREEN   = 3'd2,
      SEG_CYAN    = 3'd3,
      SEG_BLUE    = 3'd4,
      SEG_MAGENTA = 3'd5
   } seg_t;

   // STEP-mode colours as {R,G,B} on/off bits
   localparam logic [2:0] COLOUR_RED     = 3'b100;
   localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
   localparam logic [2:0] COLOUR_GREEN   = 3'b010;
   localparam logic [2:0] COLOUR_CYAN    = 3'b011;
   localparam logic [2:0] COLOUR_BLUE    = 3'b001;
   localparam logic [2:0] COLOUR_MAGENTA = 3'b101;

   function automatic logic [2:0] step_colour(input seg_t s);
      case (s)
         SEG_RED:     step_colour = COLOUR_RED;
         SEG_YELLOW:  step_colour = COLOUR_YELLOW;
         SEG_GREEN:   step_colour = COLOUR_GREEN;
         SEG_CYAN:    step_colour = COLOUR_CYAN;
         SEG_BLUE:    step_colour = COLOUR_BLUE;
         SEG_MAGENTA: step_colour = COLOUR_MAGENTA;
         default:     step_colour = '0;
      endcase
   endfunction

endpackage

// File: rtl/hue_fader_pwm_channel.sv
// One PWM colour channel: frame-synchronous duty register, comparator and
// registered active-low pad.
module pwm_channel
   import hue_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                frame,
   input  logic [PWM_BITS-1:0] target,
   input  logic                off,
   output logic                pad
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] duty;
   logic                lit;

   // Lit while duty is above the counter; full duty is lit for the whole frame
   always_comb begin
      lit = (duty > pwm_cnt) || (duty == MAX);
   end

   // Duty only changes at the frame boundary so a frame is never cut short
   always_ff @(posedge clk) begin
      if (rst) begin
         duty <= '0;
      end else if (frame) begin
         duty <= target;
      end
   end

   // Registered active-low pad; OFF overrides the duty compare
   always_ff @(posedge clk) begin
      if (rst) begin
         pad <= 1'b1;
      end else begin
         pad <= off ? 1'b1 : ~lit;
      end
   end

endmodule

// File: rtl/hue_fader.sv
// RGB status-LED driver walking the six-colour hue wheel with hard steps or
// PWM cross-fades, global brightness scaling and hold/off modes.
module hue_fader
   import hue_pkg::*;
#(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned STEP_TICKS = 7812
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                RGB_R,
   output logic                RGB_G,
   output logic                RGB_B,
   output logic [2:0]          seg,
   output logic                seg_wrap
);

   localparam int unsigned TICK_W = $clog2(STEP_TICKS + 1);
   localparam int unsigned PROD_W = 2 * PWM_BITS + 1;
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [TICK_W-1:0]   TICK_TOP = TICK_W'(STEP_TICKS - 1);

   mode_t               mode_q;
   logic                run;
   logic                off;
   logic [TICK_W-1:0]   tick_cnt;
   logic [PWM_BITS-1:0] phase;
   seg_t                seg_q;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                frame;
   logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
   logic [PWM_BITS-1:0] scl_r, scl_g, scl_b;
   logic [2:0]          colour;

   function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] t,
                                                 input logic [PWM_BITS-1:0] b);
      logic [PROD_W-1:0] prod;
      prod  = PROD_W'(t) * (PROD_W'(b) + PROD_W'(1));
      scale = prod[2*PWM_BITS-1:PWM_BITS];
   endfunction

   // Decode the mode; only STEP and FADE move the wheel
   always_comb begin
      mode_q = mode_t'(mode);
      run    = (mode_q == MODE_STEP) || (mode_q == MODE_FADE);
      off    = (mode_q == MODE_OFF);
      frame  = (pwm_cnt == MAX);
   end

   // Wheel position: tick prescaler, phase within segment, segment and wrap pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         phase    <= '0;
         seg_q    <= SEG_RED;
         seg_wrap <= 1'b0;
      end else begin
         seg_wrap <= 1'b0;
         if (run) begin
            if (tick_cnt == TICK_TOP) begin
               tick_cnt <= '0;
               phase    <= phase + 1'b1;
               if (phase == MAX) begin
                  if (seg_q == SEG_MAGENTA) begin
                     seg_q    <= SEG_RED;
                     seg_wrap <= 1'b1;
                  end else begin
                     seg_q <= seg_t'(3'(seg_q) + 3'd1);
                  end
               end
            end else begin
               tick_cnt <= tick_cnt + 1'b1;
            end
         end
      end
   end

   // Free-running PWM counter, independent of mode
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Per-channel targets; OFF uses the fade shape too, so duty loaded while
   // dark matches what HOLD would show at the frozen position
   always_comb begin
      tgt_r  = '0;
      tgt_g  = '0;
      tgt_b  = '0;
      colour = step_colour(seg_q);
      if (mode_q == MODE_STEP) begin
         tgt_r = {PWM_BITS{colour[2]}};
         tgt_g = {PWM_BITS{colour[1]}};
         tgt_b = {PWM_BITS{colour[0]}};
      end else begin
         case (seg_q)
            SEG_RED:     begin tgt_r = MAX;         tgt_g = phase;       end
            SEG_YELLOW:  begin tgt_r = MAX - phase; tgt_g = MAX;         end
            SEG_GREEN:   begin tgt_g = MAX;         tgt_b = phase;       end
            SEG_CYAN:    begin tgt_g = MAX - phase; tgt_b = MAX;         end
            SEG_BLUE:    begin tgt_r = phase;       tgt_b = MAX;         end
            SEG_MAGENTA: begin tgt_r = MAX;         tgt_b = MAX - phase; end
            default:     ;
         endcase
      end
      scl_r = scale(tgt_r, brightness);
      scl_g = scale(tgt_g, brightness);
      scl_b = scale(tgt_b, brightness);
   end

   assign seg = 3'(seg_q);

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
      .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .frame(frame),
      .target(scl_r), .off(off), .pad(RGB_R)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
      .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .frame(frame),
      .target(scl_g), .off(off), .pad(RGB_G)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
      .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt), .frame(frame),
      .target(scl_b), .off(off), .pad(RGB_B)
   );

endmodule

// File: tb/tb_hue_fader.sv
module tb_hue_fader;

  localparam int PB    = 3;
  localparam int ST    = 2;
  localparam int MAXV  = (1 << PB) - 1;
  localparam int FRAME = 1 << PB;
  localparam int WHEEL = 6 * FRAME * ST;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [PB-1:0] brightness;
  logic          RGB_R, RGB_G, RGB_B;
  logic [2:0]    seg;
  logic          seg_wrap;

  hue_fader #(.PWM_BITS(PB), .STEP_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .mode(mode), .brightness(brightness),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .seg(seg), .seg_wrap(seg_wrap)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  int m_pos = 0;
  int m_pwm = 0;
  int m_duty[3];
  int m_pad[3];
  int m_wrap = 0;

  function automatic int target(int md, int s, int ph, int ch);
    int rgb[3];
    int step_bits[6];
    step_bits = '{4, 6, 2, 3, 1, 5};
    if (md == 1) begin
      return ((step_bits[s] >> (2 - ch)) & 1) != 0 ? MAXV : 0;
    end
    case (s)
      0: rgb = '{MAXV, ph, 0};
      1: rgb = '{MAXV - ph, MAXV, 0};
      2: rgb = '{0, MAXV, ph};
      3: rgb = '{0, MAXV - ph, MAXV};
      4: rgb = '{ph, 0, MAXV};
      default: rgb = '{MAXV, 0, MAXV - ph};
    endcase
    return rgb[ch];
  endfunction

  always @(posedge clk) begin
    int s_o, ph_o, md, b;
    logic [6:0] e;
    md = int'(mode);
    b  = int'(brightness);
    if (rst) begin
      m_pos = 0; m_pwm = 0; m_wrap = 0;
      for (int unsigned c = 0; c < 3; c++) begin m_duty[c] = 0; m_pad[c] = 1; end
    end else begin
      s_o  = m_pos / (FRAME * ST);
      ph_o = (m_pos / ST) % FRAME;
      for (int unsigned c = 0; c < 3; c++) begin
        if (md == 0) m_pad[c] = 1;
        else m_pad[c] = (m_duty[c] > m_pwm || m_duty[c] == MAXV) ? 0 : 1;
        if (m_pwm == MAXV) m_duty[c] = (target(md, s_o, ph_o, c) * (b + 1)) >> PB;
      end
      m_wrap = 0;
      if (md == 1 || md == 2) begin
        m_pos = (m_pos + 1) % WHEEL;
        if (m_pos == 0) m_wrap = 1;
      end
      m_pwm = (m_pwm + 1) % FRAME;
    end
    e = {m_pad[0][0], m_pad[1][0], m_pad[2][0], 3'(m_pos / (FRAME * ST)), m_wrap[0]};
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    logic [6:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {RGB_R, RGB_G, RGB_B, seg, seg_wrap};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL pads_seg_wrap t=%0t actual RGB=%b seg=%0d wrap=%b required RGB=%b seg=%0d wrap=%b",
                 $time, a[6:4], a[3:1], a[0], e[6:4], e[3:1], e[0]);
      end
    end
  end

  task automatic check_reset();
    vectors++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b111 || seg !== 3'd0 || seg_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state t=%0t actual RGB=%b seg=%0d wrap=%b required RGB=111 seg=0 wrap=0",
               $time, {RGB_R, RGB_G, RGB_B}, seg, seg_wrap);
    end
  endtask

  task automatic wait_wrap(input int limit);
    int unsigned n;
    n = 0;
    while (seg_wrap !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (seg_wrap !== 1'b1) begin
      errors++;
      $display("FAIL seg_wrap_timeout t=%0t no seg_wrap pulse within %0d clocks", $time, limit);
    end
  endtask

  task automatic run(input int m, input int b, input int n);
    mode       = 2'(m);
    brightness = PB'(b);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd2; brightness = PB'(7);
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    run(2, 7, 30);
    run(2, 7, 170);
    pulse_rst();
    mode = 2'd1; brightness = PB'(7);
    wait_wrap(WHEEL + 4);
    run(1, 7, 110);
    run(1, 3, 40);
    run(1, 0, 30);
    run(2, 7, 37);
    run(3, 7, 50);
    run(2, 7, 20);
    run(0, 7, 10);
    run(2, 7, 30);
    pulse_rst();
    run(2, 7, 52);
    pulse_rst();
    run(2, 7, 30);
    repeat (60) begin
      if ($urandom_range(0, 15) == 0) pulse_rst();
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          int'($urandom_range(1, 80)));
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
